// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared types and defaults for the ADC channel sequencer.
package adc_seq_pkg;

    localparam int unsigned DEF_MATRIX_BITS    = 12;
    localparam int unsigned DEF_NUM_CHANNELS   = 8;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    // Sequencer FSM state encoding
    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE     = 2'd0;
    localparam seq_state_t ST_SETTLE   = 2'd1;
    localparam seq_state_t ST_CONVERT  = 2'd2;
    localparam seq_state_t ST_WAIT_OUT = 2'd3;

    // Channel index width; a single-channel build still needs one bit
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adc_seq_next_channel.sv
// adc_seq_next_channel: finds the next set mask bit above the current channel,
// wrapping to the lowest set bit; wrap flags that no set bit lies above.
module adc_seq_next_channel #(
    parameter int unsigned NUM_CHANNELS = 8,
    parameter int unsigned CH_W         = 3
) (
    input  logic [NUM_CHANNELS-1:0] mask,
    input  logic [CH_W-1:0]         current,
    output logic [CH_W-1:0]         next_ch,
    output logic                    wrap
);

    logic            found;
    logic [CH_W-1:0] above;
    logic [CH_W-1:0] lowest;

    // Descending scan so the last hit in each category is the lowest index
    always_comb begin
        found  = 1'b0;
        above  = '0;
        lowest = '0;
        for (int i = int'(NUM_CHANNELS) - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest = CH_W'(i);
                if (i > int'(current)) begin
                    above = CH_W'(i);
                    found = 1'b1;
                end
            end
        end
        next_ch = found ? above : lowest;
        wrap    = ~found;
    end

endmodule

// File: rtl/adc_channel_sequencer.sv
// adc_channel_sequencer: scans the masked analog mux channels, holds the ADC core
// in reset while the mux settles, and buffers one result for a ready/valid consumer.
// Build option: ADC_SEQ_DISCARD_FIRST_EN drops the first conversion strobe after
// every CONVERT entry and uses the second one.
module adc_channel_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned MATRIX_BITS    = DEF_MATRIX_BITS,
    parameter int unsigned NUM_CHANNELS   = DEF_NUM_CHANNELS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int unsigned CH_W          = ch_width(NUM_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_in,
    input  logic                    stop_in,
    input  logic                    continuous_in,
    input  logic [NUM_CHANNELS-1:0] channel_mask_in,
    input  logic [3:0]              settle_cycles_in,
    input  logic [2:0]              avg_control_in,
    input  logic                    adc_conv_finished_in,
    input  logic [MATRIX_BITS-1:0]  adc_result_in,
    output logic                    adc_rst_n_out,
    output logic [2:0]              adc_avg_control_out,
    output logic [CH_W-1:0]         mux_select_out,
    output logic [MATRIX_BITS-1:0]  result_out,
    output logic [CH_W-1:0]         result_channel_out,
    output logic                    result_valid_out,
    input  logic                    result_ready_in,
    output logic                    busy_out,
    output logic                    scan_done_out,
    output logic                    timeout_err_out
);

    // One counter serves both the settle countdown and the CONVERT timeout
    localparam int unsigned CNT_W = max_u(4, $clog2(TIMEOUT_CYCLES + 1));
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [NUM_CHANNELS-1:0] mask_q, mask_d;
    logic                    cont_q, cont_d;
    logic [2:0]              avg_q, avg_d;
    logic [MATRIX_BITS-1:0]  res_q, res_d;
    logic [CH_W-1:0]         res_ch_q, res_ch_d;
    logic                    valid_q, valid_d;
    logic [MATRIX_BITS-1:0]  hold_q, hold_d;
    logic                    done_q, done_d;
    logic                    tout_q, tout_d;

    logic                    use_strobe;
    logic                    buf_free;
    logic                    load;
    logic [MATRIX_BITS-1:0]  load_val;
    logic                    advance;
    logic [CNT_W-1:0]        settle_ext;

    logic [NUM_CHANNELS-1:0] fnd_mask;
    logic [CH_W-1:0]         fnd_cur;
    logic [CH_W-1:0]         nxt_ch;
    logic                    nxt_wrap;

`ifdef ADC_SEQ_DISCARD_FIRST_EN
    logic seen_q, seen_d;
`endif

    // In IDLE the finder starts above the top channel so it returns the lowest set bit
    always_comb begin
        fnd_mask = (state_q == ST_IDLE) ? channel_mask_in : mask_q;
        fnd_cur  = (state_q == ST_IDLE) ? CH_W'(NUM_CHANNELS - 1) : ch_q;
    end

    adc_seq_next_channel #(
        .NUM_CHANNELS (NUM_CHANNELS),
        .CH_W         (CH_W)
    ) u_next_channel (
        .mask    (fnd_mask),
        .current (fnd_cur),
        .next_ch (nxt_ch),
        .wrap    (nxt_wrap)
    );

    // Strobe qualification: optionally ignore the first conversion after CONVERT entry
    always_comb begin
`ifdef ADC_SEQ_DISCARD_FIRST_EN
        use_strobe = adc_conv_finished_in & seen_q;
`else
        use_strobe = adc_conv_finished_in;
`endif
    end

    // Next-state logic: FSM, counter, result buffer and channel advance
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ch_d       = ch_q;
        mask_d     = mask_q;
        cont_d     = cont_q;
        avg_d      = avg_q;
        res_d      = res_q;
        res_ch_d   = res_ch_q;
        hold_d     = hold_q;
        done_d     = 1'b0;
        tout_d     = tout_q;
        load       = 1'b0;
        load_val   = adc_result_in;
        advance    = 1'b0;
        settle_ext = CNT_W'(settle_cycles_in);
        buf_free   = ~valid_q | result_ready_in;
        // Consumer handshake drains the buffer in any state
        valid_d    = valid_q & ~result_ready_in;
`ifdef ADC_SEQ_DISCARD_FIRST_EN
        seen_d     = seen_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_in && (|channel_mask_in)) begin
                    mask_d  = channel_mask_in;
                    cont_d  = continuous_in;
                    avg_d   = avg_control_in;
                    tout_d  = 1'b0;
                    ch_d    = nxt_ch;
                    cnt_d   = settle_ext;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (stop_in) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_CONVERT;
`ifdef ADC_SEQ_DISCARD_FIRST_EN
                    seen_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_CONVERT: begin
                if (stop_in) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (use_strobe) begin
                    if (buf_free) begin
                        load    = 1'b1;
                        advance = 1'b1;
                    end else begin
                        hold_d  = adc_result_in;
                        state_d = ST_WAIT_OUT;
                        cnt_d   = '0;
                    end
`ifdef ADC_SEQ_DISCARD_FIRST_EN
                end else if (adc_conv_finished_in) begin
                    seen_d = 1'b1;
                    cnt_d  = '0;
`endif
                end else if (cnt_q == TMO_LAST) begin
                    tout_d  = 1'b1;
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_OUT: begin
                if (stop_in) begin
                    state_d = ST_IDLE;
                end else if (result_ready_in) begin
                    load     = 1'b1;
                    load_val = hold_q;
                    advance  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            res_d    = load_val;
            res_ch_d = ch_q;
            valid_d  = 1'b1;
        end

        if (advance) begin
            if (nxt_wrap && !cont_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                cnt_d   = '0;
            end else begin
                state_d = ST_SETTLE;
                ch_d    = nxt_ch;
                cnt_d   = settle_ext;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ch_q     <= '0;
            mask_q   <= '0;
            cont_q   <= 1'b0;
            avg_q    <= '0;
            res_q    <= '0;
            res_ch_q <= '0;
            valid_q  <= 1'b0;
            hold_q   <= '0;
            done_q   <= 1'b0;
            tout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            mask_q   <= mask_d;
            cont_q   <= cont_d;
            avg_q    <= avg_d;
            res_q    <= res_d;
            res_ch_q <= res_ch_d;
            valid_q  <= valid_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            tout_q   <= tout_d;
        end
    end

`ifdef ADC_SEQ_DISCARD_FIRST_EN
    // Tracks whether the throw-away strobe has been seen in this CONVERT visit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_q <= 1'b0;
        end else begin
            seen_q <= seen_d;
        end
    end
`endif

    // Outputs; the ADC core runs only while converting
    always_comb begin
        adc_rst_n_out       = (state_q == ST_CONVERT);
        busy_out            = (state_q != ST_IDLE);
        adc_avg_control_out = avg_q;
        mux_select_out      = ch_q;
        result_out          = res_q;
        result_channel_out  = res_ch_q;
        result_valid_out    = valid_q;
        scan_done_out       = done_q;
        timeout_err_out     = tout_q;
    end

endmodule

// File: tb/tb_adc_channel_sequencer.sv
// tb_adc_channel_sequencer: directed checks of the ADC channel sequencer with a
// scan-vector table plus hand-written backpressure, timeout, stop and reset sequences.
module tb_adc_channel_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic        stop_in;
    logic        continuous_in;
    logic [7:0]  channel_mask_in;
    logic [3:0]  settle_cycles_in;
    logic [2:0]  avg_control_in;
    logic        adc_conv_finished_in;
    logic [11:0] adc_result_in;
    logic        adc_rst_n_out;
    logic [2:0]  adc_avg_control_out;
    logic [2:0]  mux_select_out;
    logic [11:0] result_out;
    logic [2:0]  result_channel_out;
    logic        result_valid_out;
    logic        result_ready_in;
    logic        busy_out;
    logic        scan_done_out;
    logic        timeout_err_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adc_channel_sequencer dut (
        .clk                  (clk),
        .rst                  (rst),
        .start_in             (start_in),
        .stop_in              (stop_in),
        .continuous_in        (continuous_in),
        .channel_mask_in      (channel_mask_in),
        .settle_cycles_in     (settle_cycles_in),
        .avg_control_in       (avg_control_in),
        .adc_conv_finished_in (adc_conv_finished_in),
        .adc_result_in        (adc_result_in),
        .adc_rst_n_out        (adc_rst_n_out),
        .adc_avg_control_out  (adc_avg_control_out),
        .mux_select_out       (mux_select_out),
        .result_out           (result_out),
        .result_channel_out   (result_channel_out),
        .result_valid_out     (result_valid_out),
        .result_ready_in      (result_ready_in),
        .busy_out             (busy_out),
        .scan_done_out        (scan_done_out),
        .timeout_err_out      (timeout_err_out)
    );

    // Non-continuous scan: expected channel order listed in chs[0..n-1]
    typedef struct packed {
        logic [7:0]      mask;
        logic [3:0]      settle;
        logic [7:0]      dly;
        logic [3:0]      n;
        logic [7:0][2:0] chs;
    } scan_vec_t;

    scan_vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for the ADC core to be released; cyc returns the cycles spent waiting
    task automatic wait_convert(output int cyc);
        cyc = 0;
        while (adc_rst_n_out !== 1'b1 && cyc < 400) begin
            tick();
            cyc++;
        end
        check("wait_convert_reached", 32'(adc_rst_n_out), 1);
    endtask

    task automatic strobe(input logic [11:0] val);
`ifdef ADC_SEQ_DISCARD_FIRST_EN
        adc_conv_finished_in = 1'b1;
        adc_result_in        = ~val;
        tick();
        adc_conv_finished_in = 1'b0;
`endif
        adc_conv_finished_in = 1'b1;
        adc_result_in        = val;
        tick();
        adc_conv_finished_in = 1'b0;
        adc_result_in        = '0;
    endtask

    initial begin
        int          cyc;
        int          done_seen;
        logic [11:0] val;

        vecs[0] = '{mask: 8'h05, settle: 4'd2, dly: 8'd20, n: 4'd2,
                    chs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0}};
        vecs[1] = '{mask: 8'h80, settle: 4'd0, dly: 8'd1, n: 4'd1,
                    chs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}};
        vecs[2] = '{mask: 8'hA6, settle: 4'd5, dly: 8'd3, n: 4'd4,
                    chs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2, 3'd1}};
        vecs[3] = '{mask: 8'hFF, settle: 4'd1, dly: 8'd0, n: 4'd8,
                    chs: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
        vecs[4] = '{mask: 8'h10, settle: 4'd15, dly: 8'd2, n: 4'd1,
                    chs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4}};

        rst                  = 1'b1;
        start_in             = 1'b0;
        stop_in              = 1'b0;
        continuous_in        = 1'b0;
        channel_mask_in      = '0;
        settle_cycles_in     = '0;
        avg_control_in       = '0;
        adc_conv_finished_in = 1'b0;
        adc_result_in        = '0;
        result_ready_in      = 1'b1;
        repeat (3) tick();

        check("rst_busy", 32'(busy_out), 0);
        check("rst_adc_rst_n", 32'(adc_rst_n_out), 0);
        check("rst_valid", 32'(result_valid_out), 0);
        check("rst_result", 32'(result_out), 0);
        check("rst_done", 32'(scan_done_out), 0);
        check("rst_timeout", 32'(timeout_err_out), 0);
        rst = 1'b0;
        tick();

        // Table-driven non-continuous scans with an always-ready consumer
        for (int vi = 0; vi < 5; vi++) begin
            channel_mask_in  = vecs[vi].mask;
            settle_cycles_in = vecs[vi].settle;
            continuous_in    = 1'b0;
            result_ready_in  = 1'b1;
            start_in         = 1'b1;
            tick();
            start_in = 1'b0;
            check($sformatf("v%0d_busy_start", vi), 32'(busy_out), 1);
            check($sformatf("v%0d_first_ch", vi), 32'(mux_select_out), 32'(vecs[vi].chs[0]));
            for (int k = 0; k < int'(vecs[vi].n); k++) begin
                wait_convert(cyc);
                check($sformatf("v%0d_k%0d_settle_len", vi, k), 32'(cyc),
                      32'(vecs[vi].settle) + 1);
                check($sformatf("v%0d_k%0d_mux", vi, k), 32'(mux_select_out),
                      32'(vecs[vi].chs[k]));
                repeat (int'(vecs[vi].dly)) tick();
                val = 12'(12'h500 + vi * 16 + k);
                strobe(val);
                check($sformatf("v%0d_k%0d_valid", vi, k), 32'(result_valid_out), 1);
                check($sformatf("v%0d_k%0d_result", vi, k), 32'(result_out), 32'(val));
                check($sformatf("v%0d_k%0d_res_ch", vi, k), 32'(result_channel_out),
                      32'(vecs[vi].chs[k]));
                if (k == int'(vecs[vi].n) - 1) begin
                    check($sformatf("v%0d_done_pulse", vi), 32'(scan_done_out), 1);
                    check($sformatf("v%0d_busy_end", vi), 32'(busy_out), 0);
                end else begin
                    check($sformatf("v%0d_k%0d_no_done", vi, k), 32'(scan_done_out), 0);
                    check($sformatf("v%0d_k%0d_busy", vi, k), 32'(busy_out), 1);
                end
            end
            tick();
            check($sformatf("v%0d_done_cleared", vi), 32'(scan_done_out), 0);
            check($sformatf("v%0d_valid_drained", vi), 32'(result_valid_out), 0);
        end

        // Discard-first behaviour: 0x123 then 0x456
        channel_mask_in  = 8'h01;
        settle_cycles_in = 4'd0;
        start_in         = 1'b1;
        tick();
        start_in = 1'b0;
        wait_convert(cyc);
        adc_conv_finished_in = 1'b1;
        adc_result_in        = 12'h123;
        tick();
        adc_conv_finished_in = 1'b0;
`ifdef ADC_SEQ_DISCARD_FIRST_EN
        check("discard_first_dropped", 32'(result_valid_out), 0);
        check("discard_first_busy", 32'(busy_out), 1);
        adc_conv_finished_in = 1'b1;
        adc_result_in        = 12'h456;
        tick();
        adc_conv_finished_in = 1'b0;
        check("discard_second_result", 32'(result_out), 32'h456);
`else
        check("first_strobe_result", 32'(result_out), 32'h123);
`endif
        check("first_strobe_valid", 32'(result_valid_out), 1);
        check("first_strobe_done", 32'(scan_done_out), 1);
        tick();

        // Backpressure: second capture waits for the buffer to free
        channel_mask_in  = 8'h05;
        settle_cycles_in = 4'd0;
        result_ready_in  = 1'b0;
        start_in         = 1'b1;
        tick();
        start_in = 1'b0;
        wait_convert(cyc);
        strobe(12'h0A0);
        check("bp_ch0_result", 32'(result_out), 32'h0A0);
        check("bp_ch0_valid", 32'(result_valid_out), 1);
        wait_convert(cyc);
        check("bp_ch2_mux", 32'(mux_select_out), 2);
        strobe(12'h0B2);
        check("bp_wait_adc_held", 32'(adc_rst_n_out), 0);
        check("bp_wait_busy", 32'(busy_out), 1);
        repeat (2) tick();
        check("bp_buffer_stable", 32'(result_out), 32'h0A0);
        check("bp_buffer_ch_stable", 32'(result_channel_out), 0);
        result_ready_in = 1'b1;
        tick();
        check("bp_ch2_loaded", 32'(result_out), 32'h0B2);
        check("bp_ch2_res_ch", 32'(result_channel_out), 2);
        check("bp_ch2_valid", 32'(result_valid_out), 1);
        check("bp_done", 32'(scan_done_out), 1);
        tick();
        check("bp_drained", 32'(result_valid_out), 0);

        // Timeout on ch1, scan carries on with ch2
        channel_mask_in  = 8'h06;
        settle_cycles_in = 4'd0;
        start_in         = 1'b1;
        tick();
        start_in = 1'b0;
        wait_convert(cyc);
        check("tmo_ch1_mux", 32'(mux_select_out), 1);
        cyc = 0;
        while (adc_rst_n_out === 1'b1 && cyc < 300) begin
            tick();
            cyc++;
        end
        check("tmo_convert_len", 32'(cyc), 255);
        check("tmo_err_set", 32'(timeout_err_out), 1);
        check("tmo_no_result", 32'(result_valid_out), 0);
        check("tmo_next_ch", 32'(mux_select_out), 2);
        check("tmo_still_busy", 32'(busy_out), 1);
        wait_convert(cyc);
        strobe(12'h2C2);
        check("tmo_ch2_result", 32'(result_out), 32'h2C2);
        check("tmo_ch2_res_ch", 32'(result_channel_out), 2);
        check("tmo_sticky", 32'(timeout_err_out), 1);
        tick();
        channel_mask_in = 8'h01;
        start_in        = 1'b1;
        tick();
        start_in = 1'b0;
        check("tmo_cleared_on_start", 32'(timeout_err_out), 0);
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;

        // Continuous single channel; mid-scan input changes ignored; stop keeps full buffer
        channel_mask_in  = 8'h08;
        continuous_in    = 1'b1;
        avg_control_in   = 3'd5;
        result_ready_in  = 1'b0;
        start_in         = 1'b1;
        tick();
        start_in        = 1'b0;
        channel_mask_in = 8'hFF;
        continuous_in   = 1'b0;
        avg_control_in  = 3'd2;
        check("cont_avg_latched", 32'(adc_avg_control_out), 5);
        wait_convert(cyc);
        strobe(12'h333);
        check("cont_reenter_busy", 32'(busy_out), 1);
        check("cont_no_done", 32'(scan_done_out), 0);
        check("cont_same_ch", 32'(mux_select_out), 3);
        check("cont_result", 32'(result_out), 32'h333);
        wait_convert(cyc);
        check("cont_avg_kept", 32'(adc_avg_control_out), 5);
        strobe(12'h334);
        check("cont_wait_out", 32'(adc_rst_n_out), 0);
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        check("stop_idle", 32'(busy_out), 0);
        check("stop_no_done", 32'(scan_done_out), 0);
        check("stop_buffer_kept", 32'(result_valid_out), 1);
        check("stop_buffer_value", 32'(result_out), 32'h333);
        result_ready_in = 1'b1;
        tick();
        check("stop_buffer_drained", 32'(result_valid_out), 0);

        // Stop during SETTLE of a continuous scan
        channel_mask_in  = 8'h03;
        continuous_in    = 1'b1;
        settle_cycles_in = 4'd10;
        start_in         = 1'b1;
        tick();
        start_in = 1'b0;
        tick();
        check("settle_adc_held", 32'(adc_rst_n_out), 0);
        stop_in = 1'b1;
        tick();
        stop_in   = 1'b0;
        done_seen = 32'(scan_done_out);
        check("settle_stop_idle", 32'(busy_out), 0);
        repeat (3) begin
            tick();
            done_seen = done_seen | 32'(scan_done_out);
        end
        check("settle_stop_no_done", 32'(done_seen), 0);

        // Start with an empty mask is ignored; start beats stop in IDLE
        channel_mask_in = 8'h00;
        start_in        = 1'b1;
        tick();
        start_in = 1'b0;
        check("empty_mask_ignored", 32'(busy_out), 0);
        channel_mask_in  = 8'h01;
        settle_cycles_in = 4'd0;
        start_in         = 1'b1;
        stop_in          = 1'b1;
        tick();
        start_in = 1'b0;
        check("start_wins", 32'(busy_out), 1);
        tick();
        stop_in = 1'b0;
        check("stop_after_start", 32'(busy_out), 0);

        // Asynchronous reset in the middle of CONVERT
        channel_mask_in  = 8'h40;
        continuous_in    = 1'b1;
        avg_control_in   = 3'd5;
        result_ready_in  = 1'b0;
        start_in         = 1'b1;
        tick();
        start_in = 1'b0;
        wait_convert(cyc);
        strobe(12'h777);
        wait_convert(cyc);
        check("pre_rst_mux", 32'(mux_select_out), 6);
        check("pre_rst_valid", 32'(result_valid_out), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy_out), 0);
        check("arst_adc_rst_n", 32'(adc_rst_n_out), 0);
        check("arst_mux", 32'(mux_select_out), 0);
        check("arst_avg", 32'(adc_avg_control_out), 0);
        check("arst_result", 32'(result_out), 0);
        check("arst_res_ch", 32'(result_channel_out), 0);
        check("arst_valid", 32'(result_valid_out), 0);
        check("arst_timeout", 32'(timeout_err_out), 0);
        tick();
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
